// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shift register with load/ready handshake
module piso_serializer #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Data,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             ser_n, valid_n, done_n;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign ready = (state == IDLE) || (state == SHIFT && cnt == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    ser_n   = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    accept  = load && ready;
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sreg_n  = Data;
      ser_n   = first_bit(Data);
      valid_n = 1'b1;
    end else if (state == SHIFT && cnt != LAST) begin
      // sreg still holds the bit on serial_out at its edge, so the next bit sits one place in
      cnt_n   = cnt + CW'(1);
      valid_n = 1'b1;
      done_n  = (cnt_n == LAST);
      if (MSB_FIRST) begin
        sreg_n = sreg << 1;
        ser_n  = sreg[WIDTH-2];
      end else begin
        sreg_n = sreg >> 1;
        ser_n  = sreg[1];
      end
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      sreg_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      serial_out <= 1'b0;
      valid      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sreg       <= sreg_n;
      serial_out <= ser_n;
      valid      <= valid_n;
      done       <= done_n;
    end
  end

endmodule
